// File: rtl/velocity_calc.sv
// velocity_calc: on-demand world-frame velocity (v_x, v_y, v_z) from speed, pitch and heading.
// A quarter-wave sine LUT feeds two shared multipliers, sequenced by a five-state FSM.
module velocity_calc #(
  parameter int unsigned COORD_WIDTH = 32,
  parameter int unsigned ANGLE_WIDTH = 16,
  parameter int unsigned FRAC_BITS   = 14
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          request_velocities,
  output logic                          velocities_ready,
  output logic                          busy,
  input  logic [COORD_WIDTH-1:0]        speed,
  input  logic signed [ANGLE_WIDTH-1:0] pitch,
  input  logic [ANGLE_WIDTH-1:0]        heading,
  output logic signed [COORD_WIDTH-1:0] v_x,
  output logic signed [COORD_WIDTH-1:0] v_y,
  output logic signed [COORD_WIDTH-1:0] v_z,
  output logic                          angle_error
);

  localparam int unsigned LUT_W  = FRAC_BITS + 1;
  localparam int unsigned TRIG_W = ANGLE_WIDTH + 1;
  localparam int unsigned PROD_W = COORD_WIDTH + ANGLE_WIDTH + 1;

  localparam logic [COORD_WIDTH-1:0] SPEED_MAX = {1'b0, {(COORD_WIDTH-1){1'b1}}};
  localparam logic [ANGLE_WIDTH-1:0] DEG_90    = ANGLE_WIDTH'(90);
  localparam logic [ANGLE_WIDTH-1:0] DEG_180   = ANGLE_WIDTH'(180);
  localparam logic [ANGLE_WIDTH-1:0] DEG_270   = ANGLE_WIDTH'(270);
  localparam logic [ANGLE_WIDTH-1:0] DEG_359   = ANGLE_WIDTH'(359);
  localparam logic [ANGLE_WIDTH-1:0] DEG_360   = ANGLE_WIDTH'(360);

  typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_MUL1, ST_MUL2, ST_DONE} state_e;

  state_e state_q, state_d;

  logic signed [COORD_WIDTH-1:0] speed_q;
  logic signed [ANGLE_WIDTH-1:0] pitch_q;
  logic [ANGLE_WIDTH-1:0]        heading_q;
  logic signed [TRIG_W-1:0]      sin_p_q, cos_p_q, sin_h_q, cos_h_q;
  logic signed [TRIG_W-1:0]      sin_p_d, cos_p_d, sin_h_d, cos_h_d;
  logic                          err_q, err_d;
  logic signed [COORD_WIDTH-1:0] h_q, vy_n_q, vx_n_q, vz_n_q;

  logic [ANGLE_WIDTH-1:0]        p_abs, h_sin_idx, h_cos_idx;
  logic                          h_sin_neg, h_cos_neg;
  logic signed [COORD_WIDTH-1:0] mul_a, res0, res1;
  logic signed [TRIG_W-1:0]      mul_b0, mul_b1;
  logic signed [PROD_W-1:0]      prod0, prod1;

  // round(sin(k deg) * 2^14) for k = 0..90
  function automatic logic [LUT_W-1:0] sin_lut(input int unsigned k);
    int unsigned l;
    case (k)
      0: l = 0;         1: l = 286;       2: l = 572;       3: l = 857;       4: l = 1143;
      5: l = 1428;      6: l = 1713;      7: l = 1997;      8: l = 2280;      9: l = 2563;
      10: l = 2845;     11: l = 3126;     12: l = 3406;     13: l = 3686;     14: l = 3964;
      15: l = 4240;     16: l = 4516;     17: l = 4790;     18: l = 5063;     19: l = 5334;
      20: l = 5604;     21: l = 5872;     22: l = 6138;     23: l = 6402;     24: l = 6664;
      25: l = 6924;     26: l = 7182;     27: l = 7438;     28: l = 7692;     29: l = 7943;
      30: l = 8192;     31: l = 8438;     32: l = 8682;     33: l = 8923;     34: l = 9162;
      35: l = 9397;     36: l = 9630;     37: l = 9860;     38: l = 10087;    39: l = 10311;
      40: l = 10531;    41: l = 10749;    42: l = 10963;    43: l = 11174;    44: l = 11381;
      45: l = 11585;    46: l = 11786;    47: l = 11982;    48: l = 12176;    49: l = 12365;
      50: l = 12551;    51: l = 12733;    52: l = 12911;    53: l = 13085;    54: l = 13255;
      55: l = 13421;    56: l = 13583;    57: l = 13741;    58: l = 13894;    59: l = 14044;
      60: l = 14189;    61: l = 14330;    62: l = 14466;    63: l = 14598;    64: l = 14726;
      65: l = 14849;    66: l = 14968;    67: l = 15082;    68: l = 15191;    69: l = 15296;
      70: l = 15396;    71: l = 15491;    72: l = 15582;    73: l = 15668;    74: l = 15749;
      75: l = 15826;    76: l = 15897;    77: l = 15964;    78: l = 16026;    79: l = 16083;
      80: l = 16135;    81: l = 16182;    82: l = 16225;    83: l = 16262;    84: l = 16294;
      85: l = 16322;    86: l = 16344;    87: l = 16362;    88: l = 16374;    89: l = 16382;
      90: l = 16384;
      default: l = 0;
    endcase
    return LUT_W'(l);
  endfunction

  function automatic logic signed [TRIG_W-1:0] to_trig(input logic [LUT_W-1:0] mag, input logic neg);
    logic signed [TRIG_W-1:0] v;
    v = $signed(TRIG_W'(mag));
    return neg ? -v : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (request_velocities) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_MUL1;
      ST_MUL1:   state_d = ST_MUL2;
      ST_MUL2:   state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Quadrant folding of pitch and heading onto the quarter-wave table, plus range check
  always_comb begin
    p_abs     = pitch_q[ANGLE_WIDTH-1] ? ANGLE_WIDTH'(-pitch_q) : ANGLE_WIDTH'(pitch_q);
    err_d     = (p_abs > DEG_90) || (heading_q > DEG_359);
    sin_p_d   = to_trig(sin_lut(32'(p_abs)), pitch_q[ANGLE_WIDTH-1]);
    cos_p_d   = to_trig(sin_lut(32'(DEG_90 - p_abs)), 1'b0);
    h_sin_idx = heading_q;
    h_cos_idx = DEG_90 - heading_q;
    h_sin_neg = 1'b0;
    h_cos_neg = 1'b0;
    if (heading_q > DEG_270) begin
      h_sin_idx = DEG_360 - heading_q;
      h_cos_idx = heading_q - DEG_270;
      h_sin_neg = 1'b1;
    end else if (heading_q > DEG_180) begin
      h_sin_idx = heading_q - DEG_180;
      h_cos_idx = DEG_270 - heading_q;
      h_sin_neg = 1'b1;
      h_cos_neg = 1'b1;
    end else if (heading_q > DEG_90) begin
      h_sin_idx = DEG_180 - heading_q;
      h_cos_idx = heading_q - DEG_90;
      h_cos_neg = 1'b1;
    end
    sin_h_d = to_trig(sin_lut(32'(h_sin_idx)), h_sin_neg);
    cos_h_d = to_trig(sin_lut(32'(h_cos_idx)), h_cos_neg);
  end

  // Two multipliers: speed x pitch trig in MUL1, horizontal speed x heading trig in MUL2
  always_comb begin
    mul_a  = speed_q;
    mul_b0 = cos_p_q;
    mul_b1 = sin_p_q;
    if (state_q == ST_MUL2) begin
      mul_a  = h_q;
      mul_b0 = sin_h_q;
      mul_b1 = cos_h_q;
    end
  end

  assign prod0 = PROD_W'(mul_a) * PROD_W'(mul_b0);
  assign prod1 = PROD_W'(mul_a) * PROD_W'(mul_b1);
  assign res0  = COORD_WIDTH'(prod0 >>> FRAC_BITS);
  assign res1  = COORD_WIDTH'(prod1 >>> FRAC_BITS);

  always_ff @(posedge clk) begin
    if (reset) begin
      speed_q          <= '0;
      pitch_q          <= '0;
      heading_q        <= '0;
      sin_p_q          <= '0;
      cos_p_q          <= '0;
      sin_h_q          <= '0;
      cos_h_q          <= '0;
      err_q            <= 1'b0;
      h_q              <= '0;
      vy_n_q           <= '0;
      vx_n_q           <= '0;
      vz_n_q           <= '0;
      v_x              <= '0;
      v_y              <= '0;
      v_z              <= '0;
      angle_error      <= 1'b0;
      busy             <= 1'b0;
      velocities_ready <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (request_velocities) begin
          speed_q   <= speed[COORD_WIDTH-1] ? $signed(SPEED_MAX) : $signed(speed);
          pitch_q   <= pitch;
          heading_q <= heading;
        end
        ST_LOOKUP: begin
          sin_p_q <= sin_p_d;
          cos_p_q <= cos_p_d;
          sin_h_q <= sin_h_d;
          cos_h_q <= cos_h_d;
          err_q   <= err_d;
        end
        ST_MUL1: begin
          h_q    <= res0;
          vy_n_q <= res1;
        end
        ST_MUL2: begin
          vx_n_q <= res0;
          vz_n_q <= res1;
        end
        ST_DONE: begin
          v_x         <= err_q ? '0 : vx_n_q;
          v_y         <= err_q ? '0 : vy_n_q;
          v_z         <= err_q ? '0 : vz_n_q;
          angle_error <= err_q;
        end
        default: ;
      endcase
      busy             <= (state_d != ST_IDLE);
      velocities_ready <= (state_q == ST_DONE);
    end
  end

endmodule

// File: tb/tb_velocity_calc.sv
// Bench for velocity_calc: directed cases and randomized requests against a
// floating-point trigonometric reference model.
module tb_velocity_calc;

  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               reset;
  logic               request_velocities;
  logic               velocities_ready;
  logic               busy;
  logic [31:0]        speed;
  logic signed [15:0] pitch;
  logic [15:0]        heading;
  logic signed [31:0] v_x, v_y, v_z;
  logic               angle_error;

  int n_total = 0;
  int n_bad   = 0;

  velocity_calc dut (
    .clk                (clk),
    .reset              (reset),
    .request_velocities (request_velocities),
    .velocities_ready   (velocities_ready),
    .busy               (busy),
    .speed              (speed),
    .pitch              (pitch),
    .heading            (heading),
    .v_x                (v_x),
    .v_y                (v_y),
    .v_z                (v_z),
    .angle_error        (angle_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Q2.14 quantisation, round half away from zero
  function automatic longint q14(input real x);
    return longint'($rtoi(x * 16384.0 + ((x >= 0.0) ? 0.5 : -0.5)));
  endfunction

  // Divide by 2^14 rounding toward -infinity
  function automatic longint floor14(input longint x);
    return (x >= 0) ? x / 16384 : -((-x + 16383) / 16384);
  endfunction

  task automatic model(input logic [31:0] spd, input logic signed [15:0] p, input logic [15:0] h,
                       output longint ex, output longint ey, output longint ez, output longint eerr);
    int     pd, hd;
    longint s, hz;
    real    pr, hr;
    pd = int'(p);
    hd = int'(h);
    ex = 0; ey = 0; ez = 0;
    eerr = (pd > 90 || pd < -90 || hd > 359) ? 1 : 0;
    if (eerr == 0) begin
      s  = (longint'(spd) > 64'sd2147483647) ? 64'sd2147483647 : longint'(spd);
      pr = real'(pd) * PI / 180.0;
      hr = real'(hd) * PI / 180.0;
      hz = floor14(s * q14($cos(pr)));
      ey = floor14(s * q14($sin(pr)));
      ex = floor14(hz * q14($sin(hr)));
      ez = floor14(hz * q14($cos(hr)));
    end
  endtask

  // Called at a falling edge; returns at the falling edge where the ready pulse is seen.
  task automatic run_req(input logic [31:0] spd, input logic signed [15:0] p,
                         input logic [15:0] h, input string tag);
    longint ex, ey, ez, eerr;
    int     lat;
    model(spd, p, h, ex, ey, ez, eerr);
    speed = spd; pitch = p; heading = h; request_velocities = 1'b1;
    @(negedge clk);
    request_velocities = 1'b0;
    speed = $urandom; pitch = 16'($urandom); heading = 16'($urandom);
    check({tag, ".busy"}, longint'(busy), 1);
    check({tag, ".rdy_low"}, longint'(velocities_ready), 0);
    lat = 0;
    while (velocities_ready !== 1'b1 && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, 4);
    check({tag, ".busy_done"}, longint'(busy), 0);
    check({tag, ".v_x"}, longint'(v_x), ex);
    check({tag, ".v_y"}, longint'(v_y), ey);
    check({tag, ".v_z"}, longint'(v_z), ez);
    check({tag, ".err"}, longint'(angle_error), eerr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int     pulses;
    longint ex, ey, ez, eerr;
    logic [31:0]        rs;
    logic signed [15:0] rp;
    logic [15:0]        rh;

    reset = 1'b1; request_velocities = 1'b1;
    speed = 32'd1000; pitch = 16'sd0; heading = 16'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0; request_velocities = 1'b0;
    check("reset.busy", longint'(busy), 0);
    check("reset.rdy", longint'(velocities_ready), 0);
    check("reset.v_x", longint'(v_x), 0);
    check("reset.v_y", longint'(v_y), 0);
    check("reset.v_z", longint'(v_z), 0);
    check("reset.err", longint'(angle_error), 0);
    @(negedge clk);
    check("reset.drop_req", longint'(busy), 0);

    run_req(32'd1000, 16'sd0, 16'd0, "p0h0");
    check("p0h0.v_z_ref", longint'(v_z), 1000);
    run_req(32'd1000, 16'sd30, 16'd90, "p30h90");
    check("p30h90.v_y_ref", longint'(v_y), 500);
    check("p30h90.v_x_ref", longint'(v_x), 866);
    run_req(32'd1000, -16'sd30, 16'd180, "pm30h180");
    check("pm30h180.v_y_ref", longint'(v_y), -500);
    check("pm30h180.v_z_ref", longint'(v_z), -866);
    run_req(32'd1000, 16'sd0, 16'd360, "h360");
    check("h360.err_ref", longint'(angle_error), 1);
    run_req(32'd16384, 16'sd45, 16'd45, "p45h45");
    check("p45h45.v_y_ref", longint'(v_y), 11585);
    check("p45h45.v_x_ref", longint'(v_x), 8191);
    check("p45h45.v_z_ref", longint'(v_z), 8191);
    run_req(32'hFFFF_FFFF, 16'sd90, 16'd359, "clamp");
    check("clamp.v_y_ref", longint'(v_y), 2147483647);
    run_req(32'd1000, -16'sd91, 16'd0, "pm91");
    run_req(32'd1000, -16'sd32768, 16'd10, "pmin");
    run_req(32'd5000, -16'sd90, 16'd91, "h91");
    run_req(32'd5000, 16'sd12, 16'd181, "h181");
    run_req(32'd5000, 16'sd12, 16'd270, "h270");
    run_req(32'd5000, 16'sd12, 16'd271, "h271");
    run_req(32'd5000, 16'sd89, 16'd359, "h359");

    for (int i = 0; i < 40; i++) begin
      rs = ($urandom_range(3) == 0) ? $urandom : $urandom_range(200000);
      rp = 16'($signed($urandom_range(200)) - 100);
      rh = 16'($urandom_range(370));
      run_req(rs, rp, rh, $sformatf("rand%0d", i));
    end

    // A request arriving while busy must be ignored
    model(32'd7000, 16'sd10, 16'd200, ex, ey, ez, eerr);
    speed = 32'd7000; pitch = 16'sd10; heading = 16'd200; request_velocities = 1'b1;
    @(negedge clk);
    request_velocities = 1'b0;
    @(negedge clk);
    speed = 32'd5; pitch = 16'sd0; heading = 16'd0; request_velocities = 1'b1;
    @(negedge clk);
    request_velocities = 1'b0;
    pulses = 0;
    repeat (10) begin
      if (velocities_ready === 1'b1) pulses++;
      @(negedge clk);
    end
    check("busy_req.pulses", pulses, 1);
    check("busy_req.v_x", longint'(v_x), ex);
    check("busy_req.v_y", longint'(v_y), ey);
    check("busy_req.v_z", longint'(v_z), ez);

    // Reset in the middle of a computation aborts it
    speed = 32'd3000; pitch = 16'sd20; heading = 16'd50; request_velocities = 1'b1;
    @(negedge clk);
    request_velocities = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst.busy", longint'(busy), 0);
    check("midrst.v_x", longint'(v_x), 0);
    check("midrst.v_y", longint'(v_y), 0);
    check("midrst.v_z", longint'(v_z), 0);
    check("midrst.err", longint'(angle_error), 0);
    pulses = 0;
    repeat (8) begin
      if (velocities_ready === 1'b1) pulses++;
      @(negedge clk);
    end
    check("midrst.pulses", pulses, 0);

    run_req(32'd2000, 16'sd60, 16'd300, "after_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
